// File: rtl/pipe_stage_elastic.sv
// Elastic pipeline register: DEPTH stages of {valid, data, ctrl} with a valid/ready
// handshake, global stall, synchronous flush, bubble collapsing and an occupancy count.
module pipe_stage_elastic #(
  parameter int DATA_W     = 32,
  parameter int CTRL_W     = 16,
  parameter int DEPTH      = 1,
  parameter bit CLEAR_DATA = 1'b1,
  localparam int OCC_W     = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [OCC_W-1:0]  occupancy
);

  logic [DEPTH-1:0]  v_q, v_d;
  logic [DATA_W-1:0] d_q [DEPTH];
  logic [DATA_W-1:0] d_d [DEPTH];
  logic [CTRL_W-1:0] c_q [DEPTH];
  logic [CTRL_W-1:0] c_d [DEPTH];

  // Upstream view of each stage: stage 0 sees the input port, stage i sees stage i-1.
  logic [DEPTH-1:0]  v_up;
  logic [DATA_W-1:0] d_up [DEPTH];
  logic [CTRL_W-1:0] c_up [DEPTH];

  logic [DEPTH-1:0]  rdy;
  logic              hole;
  logic [OCC_W-1:0]  occ_cnt;

  // A stage is ready when it, or any stage nearer the output, is empty, or the
  // consumer takes the head entry; this is what collapses bubbles.
  always_comb begin
    // NOTE: blocking '=' in always_comb lets 'hole' accumulate across the loop;
    // sequential state below uses '<=' only.
    hole = out_ready;
    rdy  = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      hole   = hole | ~v_q[i];
      rdy[i] = ~stall & ~flush & hole;
    end
  end

  always_comb begin
    v_up[0] = in_valid;
    d_up[0] = in_data;
    c_up[0] = in_ctrl;
    for (int i = 1; i < DEPTH; i++) begin
      v_up[i] = v_q[i-1];
      d_up[i] = d_q[i-1];
      c_up[i] = c_q[i-1];
    end
  end

  always_comb begin
    // NOTE: every next-state signal starts as a copy of its register, so no path
    // leaves it unassigned and no latch is inferred.
    v_d = v_q;
    d_d = d_q;
    c_d = c_q;
    if (flush) begin
      v_d = '0;
      for (int i = 0; i < DEPTH; i++) begin
        c_d[i] = '0;
        if (CLEAR_DATA) d_d[i] = '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (rdy[i]) begin
          v_d[i] = v_up[i];
          if (v_up[i]) begin
            d_d[i] = d_up[i];
            c_d[i] = c_up[i];
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: the payload arrays are reset too, because the outputs must read zero
      // while reset is asserted, not only the valid bits.
      v_q <= '0;
      d_q <= '{default: '0};
      c_q <= '{default: '0};
    end else begin
      v_q <= v_d;
      d_q <= d_d;
      c_q <= c_d;
    end
  end

  always_comb begin
    occ_cnt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      occ_cnt = occ_cnt + OCC_W'(v_q[i]);
    end
  end

  assign in_ready  = rdy[0];
  assign out_valid = v_q[DEPTH-1] & ~stall & ~flush;
  assign out_data  = d_q[DEPTH-1];
  assign out_ctrl  = c_q[DEPTH-1];
  assign occupancy = occ_cnt;

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Self-checking bench for pipe_stage_elastic (DEPTH=3): vector table, directed
// corner sequences and a randomized run against a queue-based reference model.
module tb_pipe_stage_elastic;

  localparam int DATA_W = 32;
  localparam int CTRL_W = 8;
  localparam int DEPTH  = 3;

  logic              clk = 1'b0;
  logic              reset;
  logic              stall, flush, in_valid, out_ready;
  logic [DATA_W-1:0] in_data;
  logic [CTRL_W-1:0] in_ctrl;
  logic              in_ready, out_valid;
  logic [DATA_W-1:0] out_data;
  logic [CTRL_W-1:0] out_ctrl;
  logic [1:0]        occupancy;
  logic              in_ready2, out_valid2;
  logic [DATA_W-1:0] out_data2;
  logic [CTRL_W-1:0] out_ctrl2;
  logic [1:0]        occupancy2;

  int n_cmp  = 0;
  int n_fail = 0;

  pipe_stage_elastic #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .DEPTH(DEPTH), .CLEAR_DATA(1'b1)) dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_ctrl(in_ctrl),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ctrl(out_ctrl),
    .occupancy(occupancy));

  pipe_stage_elastic #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .DEPTH(DEPTH), .CLEAR_DATA(1'b0)) dut_keep (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready2), .in_data(in_data), .in_ctrl(in_ctrl),
    .out_valid(out_valid2), .out_ready(out_ready), .out_data(out_data2), .out_ctrl(out_ctrl2),
    .occupancy(occupancy2));

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
    n_cmp++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic iv, input logic [DATA_W-1:0] d, input logic [CTRL_W-1:0] c,
                       input logic ordy, input logic st, input logic fl);
    in_valid  = iv;
    in_data   = d;
    in_ctrl   = c;
    out_ready = ordy;
    stall     = st;
    flush     = fl;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    repeat (2) tick();
    @(negedge clk);
    reset = 1'b1;
    tick();
  endtask

  // Reference model: in-flight entries held oldest-first, each with its stage position.
  typedef struct {
    int                pos;
    logic [DATA_W-1:0] data;
    logic [CTRL_W-1:0] ctrl;
  } ent_t;

  ent_t              mq[$];
  logic [DATA_W-1:0] m_data_clr, m_data_keep;
  logic [CTRL_W-1:0] m_ctrl;

  function automatic logic m_in_ready();
    return !stall && !flush && (mq.size() < DEPTH || out_ready);
  endfunction

  function automatic logic m_out_valid();
    return !stall && !flush && mq.size() > 0 && mq[0].pos == DEPTH - 1;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_data_clr  = '0;
    m_data_keep = '0;
    m_ctrl      = '0;
  endtask

  // One clock edge: an entry moves one slot forward unless the entry ahead of it
  // ends up in that slot; the head leaves the last slot only when the consumer is ready.
  task automatic model_step();
    ent_t nq[$];
    ent_t e;
    int   limit;
    int   np;
    logic accept;
    if (flush) begin
      mq.delete();
      m_data_clr = '0;
      m_ctrl     = '0;
    end else if (!stall) begin
      accept = in_valid && m_in_ready();
      limit  = out_ready ? DEPTH + 1 : DEPTH;
      foreach (mq[k]) begin
        np    = (mq[k].pos + 1 < limit - 1) ? mq[k].pos + 1 : limit - 1;
        limit = np;
        if (np == DEPTH - 1 && mq[k].pos != DEPTH - 1) begin
          m_data_clr  = mq[k].data;
          m_data_keep = mq[k].data;
          m_ctrl      = mq[k].ctrl;
        end
        if (np < DEPTH) begin
          e     = mq[k];
          e.pos = np;
          nq.push_back(e);
        end
      end
      if (accept) begin
        e.pos  = 0;
        e.data = in_data;
        e.ctrl = in_ctrl;
        nq.push_back(e);
        if (DEPTH == 1) begin
          m_data_clr  = in_data;
          m_data_keep = in_data;
          m_ctrl      = in_ctrl;
        end
      end
      mq = nq;
    end
  endtask

  typedef struct {
    logic              iv;
    logic [DATA_W-1:0] id;
    logic              ordy;
    logic              e_rdy;
    logic              e_ov;
    logic [DATA_W-1:0] e_data;
    int                e_occ;
  } vec_t;

  function automatic vec_t mk(input logic iv, input logic [DATA_W-1:0] id, input logic ordy,
                              input logic e_rdy, input logic e_ov, input logic [DATA_W-1:0] e_data,
                              input int e_occ);
    vec_t v;
    v.iv = iv; v.id = id; v.ordy = ordy;
    v.e_rdy = e_rdy; v.e_ov = e_ov; v.e_data = e_data; v.e_occ = e_occ;
    return v;
  endfunction

  vec_t tbl[11];

  initial begin
    int got;
    logic st, fl;

    // Backpressure / bubble-collapse vectors, sampled before each edge, starting empty.
    tbl[0]  = mk(1'b1, 32'hA0, 1'b0, 1'b1, 1'b0, 32'h00, 0);
    tbl[1]  = mk(1'b0, 32'h00, 1'b0, 1'b1, 1'b0, 32'h00, 1);
    tbl[2]  = mk(1'b1, 32'hA1, 1'b0, 1'b1, 1'b0, 32'h00, 1);
    tbl[3]  = mk(1'b0, 32'h00, 1'b0, 1'b1, 1'b1, 32'hA0, 2);
    tbl[4]  = mk(1'b1, 32'hA2, 1'b0, 1'b1, 1'b1, 32'hA0, 2);
    tbl[5]  = mk(1'b1, 32'hA3, 1'b0, 1'b0, 1'b1, 32'hA0, 3);
    tbl[6]  = mk(1'b1, 32'hA3, 1'b1, 1'b1, 1'b1, 32'hA0, 3);
    tbl[7]  = mk(1'b0, 32'h00, 1'b1, 1'b1, 1'b1, 32'hA1, 3);
    tbl[8]  = mk(1'b0, 32'h00, 1'b1, 1'b1, 1'b1, 32'hA2, 2);
    tbl[9]  = mk(1'b0, 32'h00, 1'b1, 1'b1, 1'b1, 32'hA3, 1);
    tbl[10] = mk(1'b0, 32'h00, 1'b1, 1'b1, 1'b0, 32'hA3, 0);

    // Reset held with random inputs.
    reset = 1'b0;
    drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    #1;
    for (int k = 0; k < 4; k++) begin
      st = 1'($urandom_range(0, 1));
      fl = 1'($urandom_range(0, 1));
      drive(1'($urandom), $urandom, 8'($urandom), 1'($urandom), st, fl);
      @(negedge clk);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_data", out_data, 0);
      check("rst_out_ctrl", out_ctrl, 0);
      check("rst_occupancy", occupancy, 0);
      check("rst_in_ready", in_ready, !st && !fl);
      tick();
    end
    drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("rst_release_in_ready", in_ready, 1);
    tick();

    // Vector table.
    for (int k = 0; k < 11; k++) begin
      drive(tbl[k].iv, tbl[k].id, tbl[k].id[7:0], tbl[k].ordy, 1'b0, 1'b0);
      @(negedge clk);
      check($sformatf("tbl%0d_in_ready", k), in_ready, tbl[k].e_rdy);
      check($sformatf("tbl%0d_out_valid", k), out_valid, tbl[k].e_ov);
      check($sformatf("tbl%0d_out_data", k), out_data, tbl[k].e_data);
      check($sformatf("tbl%0d_out_ctrl", k), out_ctrl, tbl[k].e_data[7:0]);
      check($sformatf("tbl%0d_occupancy", k), occupancy, tbl[k].e_occ);
      tick();
    end

    // Streaming: 12 words, first one visible after the 3rd edge, then one per cycle.
    for (int k = 0; k < 16; k++) begin
      drive(k < 12, 32'h10 + k, 8'(k), 1'b1, 1'b0, 1'b0);
      @(negedge clk);
      check($sformatf("stream%0d_in_ready", k), in_ready, 1);
      check($sformatf("stream%0d_out_valid", k), out_valid, k >= 3 && k < 15);
      if (out_valid) begin
        check($sformatf("stream%0d_out_data", k), out_data, 32'h10 + k - 3);
        check($sformatf("stream%0d_out_ctrl", k), out_ctrl, 8'(k - 3));
      end
      tick();
    end

    // Stall with two entries inside.
    drive(1'b1, 32'hB0, 8'hB0, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 32'hB1, 8'hB1, 1'b0, 1'b0, 1'b0);
    tick();
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, 32'hEE, 8'hEE, 1'b1, 1'b1, 1'b0);
      @(negedge clk);
      check("stall_in_ready", in_ready, 0);
      check("stall_out_valid", out_valid, 0);
      check("stall_occupancy", occupancy, 2);
      tick();
    end
    drive(1'b1, 32'hEE, 8'hEE, 1'b1, 1'b0, 1'b0);
    got = 0;
    for (int k = 0; k < 8 && got < 2; k++) begin
      @(negedge clk);
      if (out_valid) begin
        check("stall_exit_order", out_data, got == 0 ? 32'hB0 : 32'hB1);
        got++;
      end
      tick();
    end
    check("stall_exit_count", got, 2);

    // Flush together with stall on a full pipe.
    do_reset();
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 32'hC0C0_0000 + k, 8'h30 + 8'(k), 1'b0, 1'b0, 1'b0);
      tick();
    end
    drive(1'b1, 32'hFF, 8'hFF, 1'b1, 1'b1, 1'b1);
    @(negedge clk);
    check("flush_pre_occupancy", occupancy, 3);
    check("flush_in_ready", in_ready, 0);
    check("flush_out_valid", out_valid, 0);
    tick();
    drive(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    check("flush_post_occupancy", occupancy, 0);
    check("flush_post_out_ctrl", out_ctrl, 0);
    check("flush_post_out_data", out_data, 0);
    check("flush_post_in_ready", in_ready, 1);
    check("flush_keep_out_data", out_data2, 32'hC0C0_0000);
    check("flush_keep_out_ctrl", out_ctrl2, 0);
    check("flush_keep_out_valid", out_valid2, 0);
    check("flush_keep_occupancy", occupancy2, 0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("flush_no_ghost", out_valid, 0);
      tick();
    end

    // Asynchronous reset while full, between clock edges.
    do_reset();
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 32'hD000_0000 + k, 8'h40 + 8'(k), 1'b0, 1'b0, 1'b0);
      tick();
    end
    drive(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
    check("areset_pre_occupancy", occupancy, 3);
    #2;
    reset = 1'b0;
    #1;
    check("areset_out_valid", out_valid, 0);
    check("areset_out_data", out_data, 0);
    check("areset_out_ctrl", out_ctrl, 0);
    check("areset_occupancy", occupancy, 0);
    drive(1'b1, 32'h1234_5678, 8'h78, 1'b1, 1'b0, 1'b0);
    tick();
    check("areset_hold_out_valid", out_valid, 0);
    check("areset_hold_out_data", out_data, 0);
    @(negedge clk);
    reset = 1'b1;
    drive(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
    tick();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("areset_after_out_valid", out_valid, 0);
      check("areset_after_occupancy", occupancy, 0);
      tick();
    end

    // Randomized run against the reference model.
    do_reset();
    model_reset();
    for (int k = 0; k < 600; k++) begin
      drive($urandom_range(0, 99) < 70, $urandom, 8'($urandom), $urandom_range(0, 99) < 60,
            $urandom_range(0, 99) < 8, $urandom_range(0, 99) < 4);
      @(negedge clk);
      check("rand_in_ready", in_ready, m_in_ready());
      check("rand_out_valid", out_valid, m_out_valid());
      check("rand_occupancy", occupancy, mq.size());
      check("rand_out_data", out_data, m_data_clr);
      check("rand_out_ctrl", out_ctrl, m_ctrl);
      check("rand_keep_out_data", out_data2, m_data_keep);
      model_step();
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_stage_elastic.md
Name: pipe_stage_elastic

Overview:
- Parametrised elastic pipeline register for the core datapath. It replaces the fixed-field inter-stage registers with one reusable block.
- It carries a packed data bus and a packed control bus through DEPTH register stages.
- It uses a valid/ready handshake, global stall, synchronous flush, bubble collapsing and an occupancy count.
- It is instantiated between pipeline stages, for example decode→execute. With DEPTH>1 it also serves as a short retiming FIFO for the wide neuron/vector operands.

Parameters:
- DATA_W, 32, width of the data payload. Register operands, immediates and vector lanes are packed by the instantiating stage.
- CTRL_W, 16, width of the control payload. Control-unit write enables, alu op, vector length fields.
- DEPTH, 1, number of register stages; legal range 1..8.
- CLEAR_DATA, 1, when 1, flush also zeroes data; when 0, flush zeroes only valid and ctrl.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- stall  in  1  global hold; freezes every stage.
- flush  in  1  synchronous kill of all in-flight entries.
- in_valid  in  1  upstream has an entry.
- in_ready  out  1  block accepts the entry this cycle.
- in_data  in  DATA_W  upstream data payload.
- in_ctrl  in  CTRL_W  upstream control payload.
- out_valid  out  1  entry available downstream.
- out_ready  in  1  downstream accepts.
- out_data  out  DATA_W  data payload of the last stage.
- out_ctrl  out  CTRL_W  control payload of the last stage.
- occupancy  out  $clog2(DEPTH+1)  count of valid stages.

Behaviour:
- State: for each stage i = 0..DEPTH-1, a valid bit v[i], data d[i] and ctrl c[i]. Stage 0 is the input side; stage DEPTH-1 drives the outputs.
- Reset (reset=0, asynchronous): all v, d and c are cleared to 0. Consequently out_valid=0, out_data=0, out_ctrl=0 and occupancy=0. in_ready depends on stall/flush only; it is 1 when both are low.
- Ready chain (combinational):
  - r[DEPTH] = out_ready.
  - r[i] = !stall && !flush && (!v[i] || r[i+1]).
  - in_ready = r[0].
  - This gives bubble collapsing: an empty stage accepts data even while downstream is blocked.
- out_valid = v[DEPTH-1] && !stall && !flush.
- out_data and out_ctrl are driven directly from d[DEPTH-1] and c[DEPTH-1], with no output gating.
- Advance, on a rising edge with flush=0: each stage i with r[i]=1 loads from its upstream neighbour.
  - The upstream of stage 0 is in_valid/in_data/in_ctrl.
  - v[i] loads upstream valid. d[i] and c[i] load upstream payload only when upstream valid=1; otherwise they hold.
- Transfers:
  - An input transfer occurs when in_valid && in_ready.
  - An output transfer occurs when out_valid && out_ready.
- Latency: an entry accepted at edge N appears at the outputs after edge N+DEPTH-1 if no stage is blocked. For DEPTH=1, out_valid is asserted in the cycle after acceptance.
- Throughput: 1 entry/cycle sustained while out_ready=1 and stall=0.
- Stall=1:
  - No stage changes.
  - in_ready=0 and out_valid=0, so no transfer occurs in either direction.
  - Contents are retained indefinitely.
- Flush=1, on the edge:
  - All v are set to 0 and all c to 0.
  - All d are set to 0 if CLEAR_DATA=1; otherwise d holds.
  - Flush has priority over stall and advance.
  - in_ready=0 and out_valid=0 during the flush cycle, so an in_valid entry offered in that cycle is not accepted.
  - The block is empty and accepting in the cycle after flush.
- Simultaneous input and output transfer with a full pipe: r[DEPTH-1]=1 propagates up the chain. All stages shift and occupancy is unchanged.
- Full condition: all v=1 and out_ready=0. Then in_ready=0 and no state changes.
- Empty condition: all v=0. Then out_valid=0.
- occupancy is the popcount of v, combinational from registers. It stays in range 0..DEPTH and never wraps.
- Reset asserted mid-transfer: in-flight entries are discarded immediately. Outputs read 0 while reset=0. No entry is delivered after reset deassertion unless it is newly accepted.
- Data and ctrl stay stable at the outputs while out_valid=1 and out_ready=0.

Test Plan (DATA_W=32, CTRL_W=8, DEPTH=3, CLEAR_DATA=1 unless stated):
- Reset: hold reset=0 with random inputs → out_valid=0, out_data=0, out_ctrl=0, occupancy=0. After release with stall=flush=0, in_ready=1.
- Streaming: in_valid=1 with data 0x10,0x11,0x12,…, out_ready=1 → 0x10 is out_valid after the 3rd edge, then one word per cycle in order, with no gaps or duplicates.
- Backpressure and bubble collapse:
  - Apply out_ready=0 and send 0xA0, then 0xA1, then 0xA2 with gaps.
  - Required: occupancy reaches 3, in_ready=0, out_data holds 0xA0.
  - Then set out_ready=1: output is 0xA0,0xA1,0xA2 on consecutive cycles, and in_ready returns to 1 the same cycle.
- Stall: with 2 entries inside, assert stall=1 for 5 cycles while in_valid=1 and out_ready=1 → in_ready=0, out_valid=0, occupancy stays 2. After release, the same 2 entries exit first.
- Flush:
  - With 3 entries, assert flush together with stall=1 and in_valid=1 (data 0xFF) → next cycle occupancy=0, out_ctrl=0, out_data=0, and 0xFF is never output.
  - Repeat with CLEAR_DATA=0 → out_data retains the last stage word while out_valid=0.
- Async reset mid-flow: drop reset between clock edges while full → outputs go to 0 immediately, with no clock edge needed.
